// File: rtl/cache_tag_query_assoc.sv
// N-way set-associative tag lookup with per-way fill, single-line invalidate and
// a set-by-set flush. Lookups run in a 2-stage pipeline: capture set, then compare.
module cache_tag_query_assoc #(
  parameter int OFFSET_SIZE = 5,
  parameter int INDEX_SIZE  = 6,
  parameter int ADDR_SIZE   = 64,
  parameter int TAG_SIZE    = ADDR_SIZE - (OFFSET_SIZE + INDEX_SIZE),
  parameter int WAYS        = 4,
  parameter int WAY_BITS    = $clog2(WAYS)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   fetchEnable_i,
  output logic                   fetchReady_o,
  input  logic [TAG_SIZE-1:0]    tag_i,
  input  logic [INDEX_SIZE-1:0]  index_i,
  input  logic [OFFSET_SIZE-1:0] offset_i,
  input  logic                   updateEnable_i,
  input  logic [WAY_BITS-1:0]    updateWay_i,
  input  logic [TAG_SIZE-1:0]    newTag_i,
  input  logic [INDEX_SIZE-1:0]  newIndex_i,
  input  logic                   invalidateEnable_i,
  input  logic [INDEX_SIZE-1:0]  invalidateIndex_i,
  input  logic [WAY_BITS-1:0]    invalidateWay_i,
  input  logic                   flush_i,
  output logic                   flushBusy_o,
  output logic                   enable_o,
  output logic                   hit_o,
  output logic [WAY_BITS-1:0]    hitWay_o,
  output logic [WAY_BITS-1:0]    victimWay_o,
  output logic [TAG_SIZE-1:0]    tag_o,
  output logic [INDEX_SIZE-1:0]  index_o,
  output logic [OFFSET_SIZE-1:0] offset_o
);
  localparam int SETS = 2 ** INDEX_SIZE;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e                  state_q;
  logic [INDEX_SIZE-1:0]   flush_cnt_q;
  logic [TAG_SIZE-1:0]     tag_q   [SETS][WAYS];
  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAY_BITS-1:0]     rr_q    [SETS];

  logic                    accept;
  logic                    do_update;
  logic                    do_inval;

  logic                    s1_vld_q;
  logic [TAG_SIZE-1:0]     s1_tags_q [WAYS];
  logic [WAYS-1:0]         s1_valid_q;
  logic [WAY_BITS-1:0]     s1_rr_q;
  logic [TAG_SIZE-1:0]     s1_tag_q;
  logic [INDEX_SIZE-1:0]   s1_index_q;
  logic [OFFSET_SIZE-1:0]  s1_offset_q;

  logic                    hit_d;
  logic [WAY_BITS-1:0]     hit_way_d;
  logic [WAY_BITS-1:0]     victim_d;

  logic                    enable_q;
  logic                    hit_q;
  logic [WAY_BITS-1:0]     hit_way_q;
  logic [WAY_BITS-1:0]     victim_q;
  logic [TAG_SIZE-1:0]     tag_out_q;
  logic [INDEX_SIZE-1:0]   index_out_q;
  logic [OFFSET_SIZE-1:0]  offset_out_q;

  // Handshake: a lookup transfers on a rising edge where fetchEnable_i and
  // fetchReady_o are both high; otherwise it is dropped and must be held.
  assign flushBusy_o  = (state_q == ST_FLUSH);
  assign fetchReady_o = ~updateEnable_i & ~invalidateEnable_i & ~flushBusy_o & ~flush_i;
  assign accept       = fetchEnable_i & fetchReady_o;

  // One array write per edge: flush step beats update, update beats invalidate.
  assign do_update = updateEnable_i & ~flushBusy_o;
  assign do_inval  = invalidateEnable_i & ~flushBusy_o & ~updateEnable_i;

  always_ff @(posedge clock_i) begin
    if (do_update) tag_q[newIndex_i][updateWay_i] <= newTag_i;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
          end
        end
        ST_FLUSH: begin
          valid_q[flush_cnt_q] <= '0;
          flush_cnt_q          <= flush_cnt_q + 1'b1;
          if (&flush_cnt_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (do_update) begin
        valid_q[newIndex_i][updateWay_i] <= 1'b1;
        rr_q[newIndex_i]                 <= rr_q[newIndex_i] + 1'b1;
      end else if (do_inval) begin
        valid_q[invalidateIndex_i][invalidateWay_i] <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      if (flushBusy_o && updateEnable_i)
        $display("TAG COLLISION: update to set %0d dropped during flush", newIndex_i);
      if (flushBusy_o && invalidateEnable_i)
        $display("TAG COLLISION: invalidate of set %0d dropped during flush", invalidateIndex_i);
      if (!flushBusy_o && updateEnable_i && invalidateEnable_i)
        $display("TAG COLLISION: invalidate of set %0d dropped by update", invalidateIndex_i);
    end
  end
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_vld_q    <= 1'b0;
      s1_valid_q  <= '0;
      s1_rr_q     <= '0;
      s1_tag_q    <= '0;
      s1_index_q  <= '0;
      s1_offset_q <= '0;
      for (int w = 0; w < WAYS; w++) s1_tags_q[w] <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_tags_q   <= tag_q[index_i];
        s1_valid_q  <= valid_q[index_i];
        s1_rr_q     <= rr_q[index_i];
        s1_tag_q    <= tag_i;
        s1_index_q  <= index_i;
        s1_offset_q <= offset_i;
      end
    end
  end

  // Scanning from the top way down leaves the lowest match / lowest invalid way.
  always_comb begin
    hit_d     = 1'b0;
    hit_way_d = '0;
    victim_d  = s1_rr_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (s1_valid_q[w] && (s1_tags_q[w] == s1_tag_q)) begin
        hit_d     = 1'b1;
        hit_way_d = WAY_BITS'(w);
      end
      if (!s1_valid_q[w]) victim_d = WAY_BITS'(w);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_q     <= 1'b0;
      hit_q        <= 1'b0;
      hit_way_q    <= '0;
      victim_q     <= '0;
      tag_out_q    <= '0;
      index_out_q  <= '0;
      offset_out_q <= '0;
    end else begin
      enable_q <= s1_vld_q;
      if (s1_vld_q) begin
        hit_q        <= hit_d;
        hit_way_q    <= hit_way_d;
        victim_q     <= victim_d;
        tag_out_q    <= s1_tag_q;
        index_out_q  <= s1_index_q;
        offset_out_q <= s1_offset_q;
      end
    end
  end

  assign enable_o    = enable_q;
  assign hit_o       = hit_q;
  assign hitWay_o    = hit_way_q;
  assign victimWay_o = victim_q;
  assign tag_o       = tag_out_q;
  assign index_o     = index_out_q;
  assign offset_o    = offset_out_q;

endmodule
